// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer: opcodes, state
// encodings, ALUOp/PCSource encodings and the per-state control decode.
package multicycle_control_pkg;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 4;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IMM   = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_IMM_EXEC  = 4'd10,
    S_IMM_WB    = 4'd11,
    S_HALT      = 4'd12
  } state_e;

  typedef struct packed {
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    mem_to_reg;
    logic    reg_dst;
    logic    reg_write;
    logic    alu_src_a;
    logic    i_or_d;
    logic    pc_write;
    logic    pc_write_cond;
    logic    pc_write_cond_ne;
    logic [1:0] alu_src_b;
    alu_op_e alu_op;
    pc_src_e pc_source;
  } ctrl_t;

  function automatic logic is_imm_op(input logic [OPC_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  // Control word for a state; last_wait gates the one-cycle write pulses.
  function automatic ctrl_t decode_ctrl(input state_e st, input logic last_wait,
                                        input logic is_bne);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = last_wait;
        c.pc_write  = last_wait;
      end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.i_or_d    = 1'b1;
        c.mem_write = last_wait;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a        = 1'b1;
        c.alu_op           = ALUOP_SUB;
        c.pc_source        = PCSRC_ALUOUT;
        c.pc_write_cond    = ~is_bne;
        c.pc_write_cond_ne = is_bne;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_IMM_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALUOP_IMM;
      end
      S_IMM_WB:   c.reg_write = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_counter.sv
// Memory wait-state counter: loads MEM_WAIT, counts down to zero and holds there.
module mem_wait_counter
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic done_o,
  output logic done_next_c_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(MEM_WAIT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign done_next_c_o = (cnt_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT_W'(MEM_WAIT);
      done_q <= (MEM_WAIT == 0);
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_next_c_o;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS instruction sequencer with memory wait states and illegal-op halt.
// Immediate ALU ops (ADDI/SLTI/ANDI/ORI) are supported when MULTICYCLE_CTRL_IMM_EN is defined.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned OP_W     = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] Op_code,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic            IorD,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            PCWriteCondNe,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            illegal_op,
  output logic [3:0]      state_dbg
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            illegal_q, illegal_d;
  logic            run_q;
  ctrl_t           ctrl_q, ctrl_d;
  logic            wait_load, wait_done, wait_done_next;

  mem_wait_counter #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .clk           (clk),
    .rst           (rst),
    .load_i        (wait_load),
    .done_o        (wait_done),
    .done_next_c_o (wait_done_next)
  );

  // Next state, latched opcode and the control word for the coming cycle.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    wait_load = 1'b0;
    ctrl_d    = '0;

    if (state_q == S_DECODE) begin
      op_d = Op_code;
    end

    // First edge after reset only arms the sequencer so FETCH gets its full length.
    if (!run_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:     if (wait_done) state_d = S_DECODE;
        S_DECODE: begin
          if (Op_code == OP_W'(OP_RTYPE)) begin
            state_d = S_EXECUTE;
          end else if ((Op_code == OP_W'(OP_LW)) || (Op_code == OP_W'(OP_SW))) begin
            state_d = S_MEM_ADDR;
          end else if ((Op_code == OP_W'(OP_BEQ)) || (Op_code == OP_W'(OP_BNE))) begin
            state_d = S_BRANCH;
          end else if (Op_code == OP_W'(OP_J)) begin
            state_d = S_JUMP;
`ifdef MULTICYCLE_CTRL_IMM_EN
          end else if (is_imm_op(OPC_W'(Op_code))) begin
            state_d = S_IMM_EXEC;
`endif
          end else begin
            state_d = S_HALT;
          end
        end
        S_MEM_ADDR:  state_d = (op_q == OP_W'(OP_LW)) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (wait_done) state_d = S_MEM_WB;
        S_MEM_WB:    state_d = S_FETCH;
        S_MEM_WRITE: if (wait_done) state_d = S_FETCH;
        S_EXECUTE:   state_d = S_ALU_WB;
        S_ALU_WB:    state_d = S_FETCH;
        S_BRANCH:    state_d = S_FETCH;
        S_JUMP:      state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_IMM_EN
        S_IMM_EXEC:  state_d = S_IMM_WB;
        S_IMM_WB:    state_d = S_FETCH;
`endif
        S_HALT:      state_d = S_HALT;
        default:     state_d = S_HALT;
      endcase
    end

    wait_load = !run_q ||
                ((state_d != state_q) &&
                 ((state_d == S_FETCH) || (state_d == S_MEM_READ) || (state_d == S_MEM_WRITE)));
    illegal_d = illegal_q || (state_d == S_HALT);
    ctrl_d    = decode_ctrl(state_d, wait_done_next, op_d == OP_W'(OP_BNE));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      run_q     <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      run_q     <= 1'b1;
      ctrl_q    <= ctrl_d;
    end
  end

  assign MemRead       = ctrl_q.mem_read;
  assign MemWrite      = ctrl_q.mem_write;
  assign IRWrite       = ctrl_q.ir_write;
  assign MemtoReg      = ctrl_q.mem_to_reg;
  assign RegDst        = ctrl_q.reg_dst;
  assign RegWrite      = ctrl_q.reg_write;
  assign ALUSrcA       = ctrl_q.alu_src_a;
  assign IorD          = ctrl_q.i_or_d;
  assign PCWrite       = ctrl_q.pc_write;
  assign PCWriteCond   = ctrl_q.pc_write_cond;
  assign PCWriteCondNe = ctrl_q.pc_write_cond_ne;
  assign ALUSrcB       = ctrl_q.alu_src_b;
  assign ALUOp         = ctrl_q.alu_op;
  assign PCSource      = ctrl_q.pc_source;
  assign illegal_op    = illegal_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: three sequencers with MEM_WAIT = 0, 2, 3 run side by side.
// Immediate-op expectations follow MULTICYCLE_CTRL_IMM_EN.
module tb_multicycle_control;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC = 4'd6, ST_ALUWB = 4'd7;
  localparam logic [3:0] ST_MWRITE = 4'd5, ST_BRANCH = 4'd8, ST_JUMP = 4'd9;
  localparam logic [3:0] ST_IEXEC = 4'd10, ST_IWB = 4'd11, ST_HALT = 4'd12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] op [3];
  logic mem_read [3], mem_write [3], ir_write [3], mem_to_reg [3], reg_dst [3];
  logic reg_write [3], alu_src_a [3], i_or_d [3], pc_write [3], pc_wc [3], pc_wcne [3];
  logic illegal [3];
  logic [1:0] alu_src_b [3], alu_op [3], pc_src [3];
  logic [3:0] st [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_control #(
      .MEM_WAIT ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
      .OP_W     (6)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .Op_code       (op[g]),
      .MemRead       (mem_read[g]),
      .MemWrite      (mem_write[g]),
      .IRWrite       (ir_write[g]),
      .MemtoReg      (mem_to_reg[g]),
      .RegDst        (reg_dst[g]),
      .RegWrite      (reg_write[g]),
      .ALUSrcA       (alu_src_a[g]),
      .IorD          (i_or_d[g]),
      .PCWrite       (pc_write[g]),
      .PCWriteCond   (pc_wc[g]),
      .PCWriteCondNe (pc_wcne[g]),
      .ALUSrcB       (alu_src_b[g]),
      .ALUOp         (alu_op[g]),
      .PCSource      (pc_src[g]),
      .illegal_op    (illegal[g]),
      .state_dbg     (st[g])
    );
  end

  int n_cmp = 0;
  int n_mis = 0;

  // Hand-derived state sequences, cycle 1..12 after reset release.
  logic [3:0] a_st0 [12] = '{0, 1, 6, 7, 0, 1, 6, 7, 0, 1, 6, 7};
  logic [3:0] a_st1 [12] = '{0, 0, 0, 1, 2, 3, 3, 3, 4, 0, 0, 0};
  logic [3:0] a_st2 [12] = '{0, 0, 0, 0, 1, 2, 5, 5, 5, 5, 0, 0};
  // Per-cycle bit masks, bit (c-1) is the expected value in cycle c.
  logic [11:0] m0_irw, m0_rw, m0_alu10, m1_mr, m1_irw, m1_rw, m2_mr, m2_mw, m2_iord;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m0_irw = 12'h111; m0_rw = 12'h888; m0_alu10 = 12'h444;
    m1_mr  = 12'hEE7; m1_irw = 12'h804; m1_rw = 12'h100;
    m2_mr  = 12'hC0F; m2_mw  = 12'h200; m2_iord = 12'h3C0;

    // Phase A: R-type (W=0), lw (W=2), sw (W=3)
    op[0] = 6'b000000; op[1] = 6'b100011; op[2] = 6'b101011;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      expect_eq($sformatf("rst state d%0d", d), 32'(st[d]), 32'(ST_FETCH));
      expect_eq($sformatf("rst MemRead d%0d", d), 32'(mem_read[d]), 0);
      expect_eq($sformatf("rst IRWrite d%0d", d), 32'(ir_write[d]), 0);
      expect_eq($sformatf("rst PCWrite d%0d", d), 32'(pc_write[d]), 0);
      expect_eq($sformatf("rst ALUSrcB d%0d", d), 32'(alu_src_b[d]), 0);
      expect_eq($sformatf("rst illegal d%0d", d), 32'(illegal[d]), 0);
    end
    @(negedge clk) rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      expect_eq($sformatf("A c%0d st0", c), 32'(st[0]), 32'(a_st0[c-1]));
      expect_eq($sformatf("A c%0d IRWrite0", c), 32'(ir_write[0]), 32'(m0_irw[c-1]));
      expect_eq($sformatf("A c%0d RegWrite0", c), 32'(reg_write[0]), 32'(m0_rw[c-1]));
      expect_eq($sformatf("A c%0d RegDst0", c), 32'(reg_dst[0]), 32'(m0_rw[c-1]));
      expect_eq($sformatf("A c%0d ALUOp10_0", c), 32'(alu_op[0] == 2'b10), 32'(m0_alu10[c-1]));
      expect_eq($sformatf("A c%0d st1", c), 32'(st[1]), 32'(a_st1[c-1]));
      expect_eq($sformatf("A c%0d MemRead1", c), 32'(mem_read[1]), 32'(m1_mr[c-1]));
      expect_eq($sformatf("A c%0d IRWrite1", c), 32'(ir_write[1]), 32'(m1_irw[c-1]));
      expect_eq($sformatf("A c%0d PCWrite1", c), 32'(pc_write[1]), 32'(m1_irw[c-1]));
      expect_eq($sformatf("A c%0d RegWrite1", c), 32'(reg_write[1]), 32'(m1_rw[c-1]));
      expect_eq($sformatf("A c%0d MemtoReg1", c), 32'(mem_to_reg[1]), 32'(m1_rw[c-1]));
      expect_eq($sformatf("A c%0d st2", c), 32'(st[2]), 32'(a_st2[c-1]));
      expect_eq($sformatf("A c%0d MemRead2", c), 32'(mem_read[2]), 32'(m2_mr[c-1]));
      expect_eq($sformatf("A c%0d MemWrite2", c), 32'(mem_write[2]), 32'(m2_mw[c-1]));
      expect_eq($sformatf("A c%0d IorD2", c), 32'(i_or_d[2]), 32'(m2_iord[c-1]));
      if (c == 4) expect_eq("A DECODE ALUSrcB1", 32'(alu_src_b[1]), 32'h3);
      if (c == 5) begin
        expect_eq("A MEM_ADDR ALUSrcA1", 32'(alu_src_a[1]), 1);
        expect_eq("A MEM_ADDR ALUSrcB1", 32'(alu_src_b[1]), 32'h2);
        op[1] = 6'b101011;  // opcode change after DECODE must not turn lw into sw
      end
    end

    // Phase B: bne (W=0), beq (W=2), sw with reset during its 2nd MEM_WRITE cycle (W=3)
    op[0] = 6'b000101; op[1] = 6'b000100; op[2] = 6'b101011;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 3) begin
        expect_eq("B bne state", 32'(st[0]), 32'(ST_BRANCH));
        expect_eq("B bne PCWriteCondNe", 32'(pc_wcne[0]), 1);
        expect_eq("B bne PCWriteCond", 32'(pc_wc[0]), 0);
        expect_eq("B bne PCSource", 32'(pc_src[0]), 32'h1);
        expect_eq("B bne ALUOp", 32'(alu_op[0]), 32'h1);
      end
      if (c == 4) begin
        expect_eq("B bne after state", 32'(st[0]), 32'(ST_FETCH));
        expect_eq("B bne after CondNe", 32'(pc_wcne[0]), 0);
      end
      if (c == 5) begin
        expect_eq("B beq state", 32'(st[1]), 32'(ST_BRANCH));
        expect_eq("B beq PCWriteCond", 32'(pc_wc[1]), 1);
        expect_eq("B beq PCWriteCondNe", 32'(pc_wcne[1]), 0);
        expect_eq("B beq PCSource", 32'(pc_src[1]), 32'h1);
      end
      if (c == 6) expect_eq("B beq after state", 32'(st[1]), 32'(ST_FETCH));
      if (c >= 7) begin
        expect_eq($sformatf("B c%0d sw state", c), 32'(st[2]), 32'(ST_MWRITE));
        expect_eq($sformatf("B c%0d sw IorD", c), 32'(i_or_d[2]), 1);
        expect_eq($sformatf("B c%0d sw MemWrite", c), 32'(mem_write[2]), 0);
      end
    end
    #2 rst = 1'b1;
    #1;
    expect_eq("B abort state", 32'(st[2]), 32'(ST_FETCH));
    expect_eq("B abort IorD", 32'(i_or_d[2]), 0);
    expect_eq("B abort MemWrite", 32'(mem_write[2]), 0);
    step();
    expect_eq("B held MemWrite", 32'(mem_write[2]), 0);
    @(negedge clk) rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      expect_eq($sformatf("B restart c%0d st2", c), 32'(st[2]), 32'(a_st2[c-1]));
      expect_eq($sformatf("B restart c%0d MemWrite2", c), 32'(mem_write[2]), 32'(m2_mw[c-1]));
    end

    // Phase C: illegal opcode (W=0), addi (W=2), j (W=3)
    op[0] = 6'b111111; op[1] = 6'b001000; op[2] = 6'b000010;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c < 3) begin
        expect_eq($sformatf("C c%0d illegal early", c), 32'(illegal[0]), 0);
      end else begin
        expect_eq($sformatf("C c%0d halt state", c), 32'(st[0]), 32'(ST_HALT));
        expect_eq($sformatf("C c%0d illegal", c), 32'(illegal[0]), 1);
        expect_eq($sformatf("C c%0d halt MemRead", c), 32'(mem_read[0]), 0);
        expect_eq($sformatf("C c%0d halt PCWrite", c), 32'(pc_write[0]), 0);
      end
      if (c == 10) op[0] = 6'b000000;  // HALT is left only by reset
`ifdef MULTICYCLE_CTRL_IMM_EN
      if (c == 5) begin
        expect_eq("C addi IMM_EXEC", 32'(st[1]), 32'(ST_IEXEC));
        expect_eq("C addi ALUOp", 32'(alu_op[1]), 32'h3);
        expect_eq("C addi ALUSrcB", 32'(alu_src_b[1]), 32'h2);
      end
      if (c == 6) begin
        expect_eq("C addi IMM_WB", 32'(st[1]), 32'(ST_IWB));
        expect_eq("C addi RegWrite", 32'(reg_write[1]), 1);
        expect_eq("C addi RegDst", 32'(reg_dst[1]), 0);
      end
      if (c == 7) expect_eq("C addi back to FETCH", 32'(st[1]), 32'(ST_FETCH));
`else
      if (c == 5 || c == 6) begin
        expect_eq($sformatf("C c%0d addi halt", c), 32'(st[1]), 32'(ST_HALT));
        expect_eq($sformatf("C c%0d addi illegal", c), 32'(illegal[1]), 1);
      end
`endif
      if (c == 6) begin
        expect_eq("C j state", 32'(st[2]), 32'(ST_JUMP));
        expect_eq("C j PCWrite", 32'(pc_write[2]), 1);
        expect_eq("C j PCSource", 32'(pc_src[2]), 32'h2);
      end
      if (c == 7) begin
        expect_eq("C j after state", 32'(st[2]), 32'(ST_FETCH));
        expect_eq("C j after PCWrite", 32'(pc_write[2]), 0);
      end
    end
    @(negedge clk) rst = 1'b1;
    #1;
    expect_eq("C rst clears illegal", 32'(illegal[0]), 0);
    expect_eq("C rst state", 32'(st[0]), 32'(ST_FETCH));
    @(negedge clk) rst = 1'b0;
    step();
    expect_eq("C restart state", 32'(st[0]), 32'(ST_FETCH));
    expect_eq("C restart illegal", 32'(illegal[0]), 0);
    expect_eq("C restart MemRead", 32'(mem_read[0]), 1);
    step();
    expect_eq("C restart DECODE", 32'(st[0]), 32'(ST_DECODE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
